logic_sweep_ctrl: RTL

- Sequencer that exhaustively exercises the four-input / two-output combinational lab function (inputs A,B,C,D; outputs F1,F2).
- Drives all 16 input combinations in order, waits a programmable settle time per vector, and samples both outputs.
- Compares the samples against golden truth tables and reports a pass/fail summary.
- Sits between board-level start/abort controls and the combinational function under test.

---
 rtl/logic_sweep_ctrl_if.sv | 17 +
 rtl/logic_sweep_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/logic_sweep_ctrl_if.sv
// logic_sweep_ctrl_if: board controls, function-under-test drive/return and sweep results
interface logic_sweep_ctrl_if;
  logic start, abort, dut_f1, dut_f2;
  logic vec_a, vec_b, vec_c, vec_d;
  logic busy, done, pass, fail_seen;
  logic [4:0] err_count;
  logic [3:0] first_fail_idx;
  logic [15:0] cap_f1, cap_f2;
  modport master (
    output start, abort, dut_f1, dut_f2,
    input vec_a, vec_b, vec_c, vec_d, busy, done, pass, fail_seen, err_count, first_fail_idx, cap_f1, cap_f2
  );
  modport slave (
    input start, abort, dut_f1, dut_f2,
    output vec_a, vec_b, vec_c, vec_d, busy, done, pass, fail_seen, err_count, first_fail_idx, cap_f1, cap_f2
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: sweeps all 16 ABCD vectors, samples F1/F2 after settling and grades them against golden tables
module logic_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F1 = 16'hFFF6,
  parameter logic [15:0] EXP_F2 = 16'hAAFA
) (
  input logic clk,
  input logic rst_n,
  logic_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state, next;
  logic [3:0] idx, cnt;
  logic go, settled, mis;
  always_comb begin
    go = state == IDLE && bus.start;
    settled = cnt == 4'(SETTLE_CYCLES - 1);
    mis = (bus.dut_f1 != EXP_F1[idx]) || (bus.dut_f2 != EXP_F2[idx]);
    next = state == IDLE ? (bus.start ? DRIVE : IDLE)
         : state == DONE ? IDLE
         : bus.abort ? IDLE
         : state == DRIVE ? (settled ? SAMPLE : DRIVE)
         : idx == 4'hF ? DONE : DRIVE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // an aborted SAMPLE cycle leaves captures and counters untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
      bus.err_count <= '0;
      bus.first_fail_idx <= '0;
      bus.fail_seen <= 1'b0;
      bus.cap_f1 <= '0;
      bus.cap_f2 <= '0;
      bus.pass <= 1'b0;
    end else if (go) begin
      idx <= '0;
      cnt <= '0;
      bus.err_count <= '0;
      bus.first_fail_idx <= '0;
      bus.fail_seen <= 1'b0;
      bus.cap_f1 <= '0;
      bus.cap_f2 <= '0;
      bus.pass <= 1'b0;
    end else if (state == DRIVE && !bus.abort) begin
      cnt <= cnt + 4'd1;
    end else if (state == SAMPLE && !bus.abort) begin
      bus.cap_f1[idx] <= bus.dut_f1;
      bus.cap_f2[idx] <= bus.dut_f2;
      if (mis) begin
        bus.err_count <= bus.err_count + 5'd1;
        if (!bus.fail_seen) begin
          bus.first_fail_idx <= idx;
          bus.fail_seen <= 1'b1;
        end
      end
      if (idx != 4'hF) begin
        idx <= idx + 4'd1;
        cnt <= '0;
      end
    end else if (state == DONE) begin
      bus.pass <= bus.err_count == 5'd0;
    end
  assign {bus.vec_a, bus.vec_b, bus.vec_c, bus.vec_d} = idx;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule
